// File: rtl/top_dequantizer.sv
// JPEG inverse-quantization stage: multiplies each incoming coefficient by its
// luminance step size and emits a saturated signed DCT coefficient.

module quant_matrix_rom (
    input  logic [5:0] addr,
    output logic [7:0] data
);
    // Standard JPEG luminance quantization table, natural (row-major) order.
    always_comb begin
        data = 8'd0;
        case (addr)
            6'd0:  data = 8'd16;  6'd1:  data = 8'd11;  6'd2:  data = 8'd10;  6'd3:  data = 8'd16;
            6'd4:  data = 8'd24;  6'd5:  data = 8'd40;  6'd6:  data = 8'd51;  6'd7:  data = 8'd61;
            6'd8:  data = 8'd12;  6'd9:  data = 8'd12;  6'd10: data = 8'd14;  6'd11: data = 8'd19;
            6'd12: data = 8'd26;  6'd13: data = 8'd58;  6'd14: data = 8'd60;  6'd15: data = 8'd55;
            6'd16: data = 8'd14;  6'd17: data = 8'd13;  6'd18: data = 8'd16;  6'd19: data = 8'd24;
            6'd20: data = 8'd40;  6'd21: data = 8'd57;  6'd22: data = 8'd69;  6'd23: data = 8'd56;
            6'd24: data = 8'd14;  6'd25: data = 8'd17;  6'd26: data = 8'd22;  6'd27: data = 8'd29;
            6'd28: data = 8'd51;  6'd29: data = 8'd87;  6'd30: data = 8'd80;  6'd31: data = 8'd62;
            6'd32: data = 8'd18;  6'd33: data = 8'd22;  6'd34: data = 8'd37;  6'd35: data = 8'd56;
            6'd36: data = 8'd68;  6'd37: data = 8'd109; 6'd38: data = 8'd103; 6'd39: data = 8'd77;
            6'd40: data = 8'd24;  6'd41: data = 8'd35;  6'd42: data = 8'd55;  6'd43: data = 8'd64;
            6'd44: data = 8'd81;  6'd45: data = 8'd104; 6'd46: data = 8'd113; 6'd47: data = 8'd92;
            6'd48: data = 8'd49;  6'd49: data = 8'd64;  6'd50: data = 8'd78;  6'd51: data = 8'd87;
            6'd52: data = 8'd103; 6'd53: data = 8'd121; 6'd54: data = 8'd120; 6'd55: data = 8'd101;
            6'd56: data = 8'd72;  6'd57: data = 8'd92;  6'd58: data = 8'd95;  6'd59: data = 8'd98;
            6'd60: data = 8'd112; 6'd61: data = 8'd100; 6'd62: data = 8'd103; 6'd63: data = 8'd99;
            default: data = 8'd0;
        endcase
    end
endmodule

module top_dequantizer #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  q_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] dct_out,
    output logic [5:0]              out_addr,
    output logic                    out_last
);
    // Handshake: a beat transfers on a rising edge where valid && ready; the
    // producer may not retract valid, and ready never depends on valid.

    localparam int PROD_W = IN_W + 9;
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(1 << (OUT_W - 1)));

    logic [5:0]              idx;
    logic [7:0]              rom_q;
    logic signed [IN_W-1:0]  s1_coef;
    logic [7:0]              s1_q;
    logic [5:0]              s1_idx;
    logic                    s1_valid;
    logic signed [8:0]       q_ext;
    logic signed [PROD_W-1:0] product;
    logic signed [OUT_W-1:0] sat_val;
    logic                    in_xfer;
    logic                    s2_load;

    quant_matrix_rom u_rom (
        .addr (idx),
        .data (rom_q)
    );

    assign in_ready = !s1_valid || !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign s2_load  = s1_valid && (!out_valid || out_ready);

    // Step sizes are unsigned, so widen with a zero MSB before the signed multiply.
    assign q_ext   = $signed({1'b0, s1_q});
    assign product = PROD_W'(s1_coef) * PROD_W'(q_ext);

    always_comb begin
        sat_val = product[OUT_W-1:0];
        if (product > SAT_MAX)
            sat_val = SAT_MAX[OUT_W-1:0];
        else if (product < SAT_MIN)
            sat_val = SAT_MIN[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            idx <= 6'd0;
        else if (in_xfer)
            idx <= idx + 6'd1;
    end

    // S1 refills whenever it is empty or its contents move on to S2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_coef  <= '0;
            s1_q     <= 8'd0;
            s1_idx   <= 6'd0;
        end else if (s2_load || !s1_valid) begin
            s1_valid <= in_xfer;
            if (in_xfer) begin
                s1_coef <= q_in;
                s1_q    <= rom_q;
                s1_idx  <= idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            dct_out   <= '0;
            out_addr  <= 6'd0;
            out_last  <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            dct_out   <= sat_val;
            out_addr  <= s1_idx;
            out_last  <= (s1_idx == 6'd63);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_top_dequantizer.sv
// Self-checking bench for top_dequantizer: a reference model pushes expected
// beats on each accepted input and the output side pops and compares them.

module tb_top_dequantizer;
    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [7:0] q_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic signed [11:0] dct_out;
    logic [5:0]        out_addr;
    logic              out_last;

    top_dequantizer #(.IN_W(8), .OUT_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q_in      (q_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dct_out   (dct_out),
        .out_addr  (out_addr),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int rom_tab [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };

    logic [18:0] exp_q [$];
    logic [18:0] log_q [$];
    logic [7:0]  src_q [$];
    logic [5:0]  m_idx = 6'd0;
    int n_checks = 0;
    int n_fail = 0;
    int fires = 0;
    int stalls = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [11:0] sat_mul(input logic signed [7:0] c, input int qv);
        int p;
        p = int'(c) * qv;
        if (p > 2047) p = 2047;
        else if (p < -2048) p = -2048;
        return p[11:0];
    endfunction

    // One clock cycle: drive at negedge, evaluate both handshakes, advance.
    task automatic step(input logic iv, input logic ordy);
        logic [18:0] e;
        in_valid  = iv && (src_q.size() > 0);
        q_in      = (src_q.size() > 0) ? src_q[0] : 8'sd0;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            fires++;
            log_q.push_back({out_last, out_addr, dct_out});
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_beat", {13'd0, out_last, out_addr, dct_out}, {13'd0, e});
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back({m_idx == 6'd63, m_idx, sat_mul(q_in, rom_tab[m_idx])});
            void'(src_q.pop_front());
            m_idx = m_idx + 6'd1;
        end
        if (in_valid && !in_ready) stalls++;
        @(negedge clk);
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((exp_q.size() > 0 || src_q.size() > 0) && n < max_cycles) begin
            step(1'b1, 1'b1);
            n++;
        end
        check("drain_done", 32'(exp_q.size() + src_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [18:0] h;
        logic [18:0] l;
        int last_cnt;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_dct_out", 32'(dct_out), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Unit coefficients reproduce the ROM table; latency check on the first beat
        for (int i = 0; i < 64; i++) src_q.push_back(8'd1);
        log_q.delete();
        step(1'b1, 1'b1);
        check("lat_after_edge1", 32'(out_valid), 32'd0);
        step(1'b1, 1'b1);
        check("lat_after_edge2", 32'(out_valid), 32'd1);
        drain(200);
        check("blk1_count", 32'(log_q.size()), 32'd64);
        last_cnt = 0;
        foreach (log_q[i]) if (log_q[i][18]) last_cnt++;
        check("blk1_last_count", 32'(last_cnt), 32'd1);
        l = log_q[63];
        check("blk1_idx63", 32'(l), {13'd0, 1'b1, 6'd63, 12'd99});

        // Two back-to-back blocks with boundary values at idx 0 and 63
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 64; i++) begin
                if (i == 0) src_q.push_back(b == 0 ? 8'hFD : 8'd127);
                else if (i == 63) src_q.push_back(b == 0 ? 8'd127 : 8'h80);
                else src_q.push_back(8'($urandom_range(0, 255)));
            end
        end
        log_q.delete();
        fires = 0;
        stalls = 0;
        for (int i = 0; i < 130; i++) step(1'b1, 1'b1);
        check("b2b_fires", 32'(fires), 32'd128);
        check("b2b_stalls", 32'(stalls), 32'd0);
        check("b2b_pending", 32'(exp_q.size()), 32'd0);
        if (log_q.size() == 128) begin
            l = log_q[0];
            check("idx0_neg3", 32'(l[11:0]), 32'hFD0);
            l = log_q[63];
            check("idx63_sat_hi", 32'(l[11:0]), 32'h7FF);
            l = log_q[64];
            check("idx0_127", 32'(l[11:0]), 32'h7F0);
            check("wrap_addr0", 32'(l[17:12]), 32'd0);
            l = log_q[127];
            check("idx63_sat_lo", 32'(l[11:0]), 32'h800);
        end else begin
            check("b2b_log_size", 32'(log_q.size()), 32'd128);
        end

        // Backpressure: hold out_ready low for 5 cycles with both stages full
        for (int i = 0; i < 20; i++) src_q.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
        check("stall_pre_valid", 32'(out_valid), 32'd1);
        h = {out_last, out_addr, dct_out};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_hold", 32'({out_last, out_addr, dct_out}), 32'(h));
        end
        drain(200);

        // Random valid/ready toggling over three blocks
        for (int i = 0; i < 192; i++) src_q.push_back(8'($urandom_range(0, 255)));
        for (int n = 0; n < 4000 && src_q.size() > 0; n++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        check("rand_src_empty", 32'(src_q.size()), 32'd0);
        drain(200);

        // Reset mid-block at coefficient 30
        for (int i = 0; i < 64; i++) src_q.push_back(8'd2);
        for (int n = 0; n < 200 && m_idx != 6'd30; n++) step(1'b1, 1'b1);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_dct_out", 32'(dct_out), 32'd0);
        check("mid_rst_out_addr", 32'(out_addr), 32'd0);
        check("mid_rst_out_last", 32'(out_last), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        src_q.delete();
        m_idx = 6'd0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 64; i++) src_q.push_back(8'd1);
        log_q.delete();
        drain(200);
        if (log_q.size() > 0) begin
            l = log_q[0];
            check("post_rst_first", 32'(l), {13'd0, 1'b0, 6'd0, 12'd16});
        end else begin
            check("post_rst_outputs", 32'(log_q.size()), 32'd64);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/top_dequantizer.md
# top_dequantizer

Inverse-quantization stage for the JPEG decoder path. It accepts a stream of signed 8-bit quantized coefficients, 64 per 8x8 block in natural (row-major) order, and tracks the coefficient index internally. Each coefficient is multiplied by its entry from `quant_matrix_rom`, and the block emits saturated signed 12-bit DCT coefficients to the IDCT. The same ROM instance type and table are shared with the encoder-side quantizer, so quantize/dequantize use identical step sizes.

## Interface
- `IN_W`, 8, width of signed quantized coefficient input
- `OUT_W`, 12, width of signed dequantized DCT output
- `clk`  input  1  rising-edge clock, single clock domain
- `rst`  input  1  asynchronous, active-low reset (asserted when 0)
- `in_valid`  input  1  `q_in` holds a coefficient
- `in_ready`  output  1  block can accept a coefficient this cycle
- `q_in`  input  IN_W  signed quantized coefficient
- `out_valid`  output  1  `dct_out` holds a result
- `out_ready`  input  1  downstream accepts the result this cycle
- `dct_out`  output  OUT_W  signed dequantized coefficient, saturated
- `out_addr`  output  6  coefficient index (0..63) of `dct_out`
- `out_last`  output  1  high with the coefficient at index 63

## Operation
- Input transfer happens when `in_valid && in_ready` on a rising edge. Output transfer happens when `out_valid && out_ready`.
- `idx` is a 6-bit index counter. It increments on each input transfer and wraps from 63 to 0 with no gap cycle. It drives the ROM `addr` combinationally.
- The ROM is the 8-bit unsigned standard JPEG luminance table: index 0 = 16, index 1 = 11, index 63 = 99.
- Stage 1 (S1), on input transfer, registers:
  - `s1_coef <= q_in`
  - `s1_q <= rom[idx]`
  - `s1_idx <= idx`
  - `s1_valid <= 1`
- Stage 2 (S2) is the output register:
  - The product is `s1_coef * {1'b0, s1_q}`, computed as a 17-bit signed value. The multiply is exact.
  - The product is saturated to `[-(2^(OUT_W-1)), 2^(OUT_W-1)-1]`, which is [-2048, 2047] at default widths.
  - S2 registers the saturated value into `dct_out`, `s1_idx` into `out_addr`, and `(s1_idx==63)` into `out_last`.
- Advance rules:
  - S2 loads when `s1_valid && (!out_valid || out_ready)`.
  - S1 loads or empties when S2 loads, or when S1 is empty.
  - `in_ready = !s1_valid || !out_valid || out_ready` (combinational, no dependency on `in_valid`).
- Backpressure: when `out_ready` is low with both stages full, `in_ready` drops to 0 and all registers hold. No data is lost or duplicated.
- There is no explicit state machine beyond the per-stage valid flags. The block boundary is implied by the `idx` wrap.

## Timing
- Reset (`rst`=0, asynchronous): `idx`=0, `s1_valid`=0, `out_valid`=0, `dct_out`=0, `out_addr`=0, `out_last`=0. After reset, `in_ready`=1.
- Latency: an input accepted at edge N appears with `out_valid`=1 after edge N+1, provided `out_ready` was high or S2 was empty.
- Throughput: 1 coefficient/cycle sustained while `out_ready`=1; 64 cycles per block.
- Simultaneous output transfer and S1 advance in one cycle is required. The pipeline never bubbles under continuous valid/ready.
- `out_valid` with `dct_out`, `out_addr`, and `out_last` stays stable until the output transfer completes.
- Reset mid-block discards both stages and returns `idx` to 0. The next accepted coefficient is index 0.
- Zero input yields 0 output. Saturation applies symmetrically using the asymmetric two's-complement bounds.

## Test plan
- Reset, then stream `q_in`=1 for 64 coefficients with `out_ready`=1 -> `dct_out` equals the ROM table in order (16, 11, ..., 99). `out_addr` runs 0..63. `out_last` is high only at 63. First `out_valid` appears 2 edges after the first accept.
- Idx 0 with `q_in`=-3 -> -48. Idx 0 with `q_in`=127 -> 2032. Idx 63 with `q_in`=127 -> 2047 (saturated from 12573). Idx 63 with `q_in`=-128 -> -2048.
- Two back-to-back blocks with continuous `in_valid`/`out_ready` -> 128 outputs in 128 cycles. `out_addr` wraps 63 -> 0 with no gap cycle.
- Hold `out_ready`=0 for 5 cycles mid-stream -> `in_ready` falls once both stages fill. `dct_out`/`out_addr` are held. On release, no coefficient is dropped or repeated.
- Random `in_valid`/`out_ready` toggling over 3 blocks against a reference model -> an exact output sequence match.
- Assert `rst` low at coefficient 30 -> all outputs return to reset values immediately. The next block restarts at `out_addr`=0.
